ov7670_capture_param: RTL and testbench



---
 rtl/ov7670_cap_pkg.sv | 15 +
 rtl/ov7670_byte_pair.sv | 28 ++
 rtl/ov7670_capture_param.sv | 136 +++++++++++++
 tb/tb_ov7670_capture_param.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/ov7670_cap_pkg.sv
// rtl/ov7670_cap_pkg.sv - shared state encoding, pixel widths and format helper for the OV7670 capture block
package ov7670_cap_pkg;

    localparam logic [1:0] ST_WAIT_VS = 2'd0;
    localparam logic [1:0] ST_ARMED   = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;

    localparam int RGB444_W = 12;
    localparam int RGB565_W = 16;

    function automatic logic [11:0] rgb565_to_444(input logic [15:0] p);
        return {p[15:12], p[10:7], p[4:1]};
    endfunction

endpackage

// File: rtl/ov7670_byte_pair.sv
// rtl/ov7670_byte_pair.sv - joins the two sensor bytes of a pixel into a registered RGB565 word
module ov7670_byte_pair (
    input  logic        pclk,
    input  logic        rst,
    input  logic        href,
    input  logic        phase,
    input  logic [7:0]  d,
    output logic [15:0] pix,
    output logic        pix_valid
);

    logic [7:0] hi;

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            hi        <= 8'd0;
            pix       <= 16'd0;
            pix_valid <= 1'b0;
        end else begin
            pix_valid <= href & phase;
            if (href && !phase)
                hi <= d;
            if (href && phase)
                pix <= {hi, d};
        end
    end

endmodule

// File: rtl/ov7670_capture_param.sv
// rtl/ov7670_capture_param.sv - OV7670 capture front end with window, decimation and single-shot control
module ov7670_capture_param
    import ov7670_cap_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int OUT_W    = 12,
    parameter int ADDR_W   = 19
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic              vsync,
    input  logic              href,
    input  logic [7:0]        d,
    input  logic              continuous,
    input  logic              arm,
    input  logic              decim,
    output logic [ADDR_W-1:0] addr,
    output logic [OUT_W-1:0]  dout,
    output logic              we,
    output logic              busy,
    output logic              frame_done,
    output logic              line_err
);

    localparam logic [ADDR_W-1:0] H_LIM    = ADDR_W'(H_ACTIVE);
    localparam logic [ADDR_W-1:0] V_LIM    = ADDR_W'(V_ACTIVE);
    localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

    logic [1:0]        state;
    logic              vs_q, href_q, phase, decim_q;
    logic              arm_pend, arm_held, keep_q;
    logic [ADDR_W-1:0] col, row;
    logic [15:0]       pix;
    logic              pix_valid;
    logic              vs_rise, vs_fall, arm_req, pix_in, in_win, keep;

    assign vs_rise = vsync & ~vs_q;
    assign vs_fall = ~vsync & vs_q;
    assign arm_req = arm & ~continuous;
    assign pix_in  = href & phase;
    assign in_win  = (col < H_LIM) && (row < V_LIM) && (!decim_q || (!col[0] && !row[0]));
    // A second byte arriving with vsync high is a dangling half-frame pixel and is dropped.
    assign keep    = (state == ST_CAPTURE) && pix_in && !vsync && in_win;
    assign we      = keep_q & pix_valid;

    ov7670_byte_pair u_byte_pair (
        .pclk      (pclk),
        .rst       (rst),
        .href      (href),
        .phase     (phase),
        .d         (d),
        .pix       (pix),
        .pix_valid (pix_valid)
    );

    generate
        if (OUT_W == RGB565_W) begin : g_565
            assign dout = pix;
        end else begin : g_444
            assign dout = rgb565_to_444(pix);
        end
    endgenerate

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state      <= ST_WAIT_VS;
            vs_q       <= 1'b0;
            href_q     <= 1'b0;
            phase      <= 1'b0;
            decim_q    <= 1'b0;
            arm_pend   <= 1'b0;
            arm_held   <= 1'b0;
            keep_q     <= 1'b0;
            col        <= '0;
            row        <= '0;
            addr       <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            line_err   <= 1'b0;
        end else begin
            vs_q       <= vsync;
            href_q     <= href;
            phase      <= href ? ~phase : 1'b0;
            keep_q     <= keep;
            frame_done <= 1'b0;

            if (we && addr != ADDR_MAX)
                addr <= addr + 1'b1;

            // An arm seen mid-capture is parked so it survives the end-of-frame clear.
            if (arm_req) begin
                if (busy) arm_held <= 1'b1;
                else      arm_pend <= 1'b1;
            end

            case (state)
                ST_WAIT_VS: begin
                    if (vsync && (continuous || arm_pend))
                        state <= ST_ARMED;
                end
                ST_ARMED: begin
                    if (vs_fall) begin
                        busy     <= 1'b1;
                        addr     <= '0;
                        row      <= '0;
                        col      <= '0;
                        line_err <= 1'b0;
                        decim_q  <= decim;
                        state    <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (vs_rise) begin
                        frame_done <= 1'b1;
                        busy       <= 1'b0;
                        arm_pend   <= arm_held | arm_req;
                        arm_held   <= 1'b0;
                        state      <= continuous ? ST_ARMED : ST_WAIT_VS;
                    end else begin
                        if (pix_in)
                            col <= (&col) ? col : col + 1'b1;
                        if (href_q && !href) begin
                            if (col != H_LIM || phase)
                                line_err <= 1'b1;
                            row <= (&row) ? row : row + 1'b1;
                            col <= '0;
                        end
                    end
                end
                default: state <= ST_WAIT_VS;
            endcase
        end
    end

endmodule

// File: tb/tb_ov7670_capture_param.sv
// tb/tb_ov7670_capture_param.sv - scoreboard bench for ov7670_capture_param over three parameter sets
module tb_ov7670_capture_param;

    typedef struct {
        int cyc;
        int addr;
        int dat;
    } exp_t;

    logic        pclk, rst, vsync, href, continuous, arm, decim;
    logic [7:0]  d;
    logic [18:0] addr_a, addr_b, addr_c;
    logic [11:0] dout_a, dout_c;
    logic [15:0] dout_b;
    logic        we_a, we_b, we_c, busy_a, busy_b, busy_c;
    logic        fd_a, fd_b, fd_c, le_a, le_b, le_c;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   fd_cnt_a = 0;
    int   exp_fd = 0;
    bit   dec_exp = 0;
    exp_t qa[$], qb[$], qc[$];

    ov7670_capture_param #(.H_ACTIVE(4), .V_ACTIVE(2), .OUT_W(12), .ADDR_W(19)) dut_a (
        .pclk(pclk), .rst(rst), .vsync(vsync), .href(href), .d(d),
        .continuous(continuous), .arm(arm), .decim(decim),
        .addr(addr_a), .dout(dout_a), .we(we_a), .busy(busy_a),
        .frame_done(fd_a), .line_err(le_a));

    ov7670_capture_param #(.H_ACTIVE(4), .V_ACTIVE(2), .OUT_W(16), .ADDR_W(19)) dut_b (
        .pclk(pclk), .rst(rst), .vsync(vsync), .href(href), .d(d),
        .continuous(continuous), .arm(arm), .decim(decim),
        .addr(addr_b), .dout(dout_b), .we(we_b), .busy(busy_b),
        .frame_done(fd_b), .line_err(le_b));

    ov7670_capture_param #(.H_ACTIVE(4), .V_ACTIVE(4), .OUT_W(12), .ADDR_W(19)) dut_c (
        .pclk(pclk), .rst(rst), .vsync(vsync), .href(href), .d(d),
        .continuous(continuous), .arm(arm), .decim(decim),
        .addr(addr_c), .dout(dout_c), .we(we_c), .busy(busy_c),
        .frame_done(fd_c), .line_err(le_c));

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] to444(input logic [15:0] p);
        return {p[15:12], p[10:7], p[4:1]};
    endfunction

    always @(negedge pclk) begin
        exp_t e;
        if (fd_a) fd_cnt_a++;
        if (we_a) begin
            if (qa.size() == 0) check("a_unexpected_we", 32'(we_a), 32'd0);
            else begin
                e = qa.pop_front();
                check("a_addr", 32'(addr_a), e.addr);
                check("a_dout", 32'(dout_a), e.dat);
                check("a_we_cycle", cyc, e.cyc);
            end
        end
        if (we_b) begin
            if (qb.size() == 0) check("b_unexpected_we", 32'(we_b), 32'd0);
            else begin
                e = qb.pop_front();
                check("b_addr", 32'(addr_b), e.addr);
                check("b_dout", 32'(dout_b), e.dat);
                check("b_we_cycle", cyc, e.cyc);
            end
        end
        if (we_c) begin
            if (qc.size() == 0) check("c_unexpected_we", 32'(we_c), 32'd0);
            else begin
                e = qc.pop_front();
                check("c_addr", 32'(addr_c), e.addr);
                check("c_dout", 32'(dout_c), e.dat);
                check("c_we_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic vs_high(input int n);
        vsync = 1'b1;
        href  = 1'b0;
        repeat (n) tick();
    endtask

    // One vsync-low period of nl lines x np pixels; expectations are queued only while cap holds.
    task automatic drive_frame(input int nl, input int np, input bit cap, input int mode,
                               input int arm_line, input int rst_pix);
        int          ea, ec, idx;
        bit          cap_now;
        logic [15:0] v;
        exp_t        e;
        ea = 0; ec = 0; cap_now = cap;
        vsync = 1'b0;
        repeat (3) tick();
        for (int r = 0; r < nl; r++) begin
            if (r == arm_line) begin arm = 1'b1; tick(); arm = 1'b0; end
            for (int c = 0; c < np; c++) begin
                idx = r * np + c;
                if (idx == rst_pix) begin
                    tick();
                    @(negedge pclk);
                    #1 rst = 1'b1;
                    #1;
                    check("rst_addr", 32'(addr_a), 32'd0);
                    check("rst_dout", 32'(dout_a), 32'd0);
                    check("rst_we", 32'(we_a), 32'd0);
                    check("rst_busy", 32'(busy_a), 32'd0);
                    cap_now = 1'b0;
                    repeat (2) tick();
                    rst = 1'b0;
                end
                case (mode)
                    0:       v = 16'hF81F;
                    1:       v = 16'(32'h1111 * idx);
                    default: v = 16'($urandom);
                endcase
                tick(); href = 1'b1; d = v[15:8];
                tick(); d = v[7:0];
                if (cap_now && (!dec_exp || (c % 2 == 0 && r % 2 == 0))) begin
                    e.cyc = cyc + 1;
                    if (c < 4 && r < 2) begin
                        e.addr = ea; e.dat = 32'(to444(v)); qa.push_back(e);
                        e.dat = 32'(v); qb.push_back(e);
                        ea++;
                    end
                    if (c < 4 && r < 4) begin
                        e.addr = ec; e.dat = 32'(to444(v)); qc.push_back(e);
                        ec++;
                    end
                end
            end
            tick(); href = 1'b0; d = 8'h00;
            repeat (2) tick();
        end
    endtask

    task automatic end_checks(input string tag, input int exp_le);
        check({tag, "_qa_left"}, qa.size(), 32'd0);
        check({tag, "_qb_left"}, qb.size(), 32'd0);
        check({tag, "_qc_left"}, qc.size(), 32'd0);
        check({tag, "_frame_done_count"}, fd_cnt_a, exp_fd);
        check({tag, "_line_err"}, 32'(le_a), exp_le);
        check({tag, "_busy"}, 32'(busy_a), 32'd0);
        qa.delete(); qb.delete(); qc.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; vsync = 1'b0; href = 1'b0; d = 8'h00;
        continuous = 1'b1; arm = 1'b0; decim = 1'b0;
        repeat (3) tick();
        check("reset_addr", 32'(addr_a), 32'd0);
        check("reset_dout", 32'(dout_b), 32'd0);
        check("reset_we", 32'(we_a), 32'd0);
        check("reset_busy", 32'(busy_a), 32'd0);
        check("reset_frame_done", 32'(fd_a), 32'd0);
        check("reset_line_err", 32'(le_a), 32'd0);
        rst = 1'b0;
        tick();

        // Continuous capture of a 4x2 frame of 0xF81F pixels.
        vs_high(3);
        drive_frame(2, 4, 1'b1, 0, -1, -1);
        check("t1_busy_in_frame", 32'(busy_a), 32'd1);
        continuous = 1'b0;
        vs_high(3);
        exp_fd = 1;
        end_checks("t1", 0);

        // Single-shot: two idle frames, then an arm that captures exactly one frame.
        drive_frame(2, 4, 1'b0, 2, -1, -1);
        vs_high(3);
        drive_frame(2, 4, 1'b0, 2, -1, -1);
        vs_high(3);
        drive_frame(2, 4, 1'b0, 2, 1, -1);
        vs_high(3);
        drive_frame(2, 4, 1'b1, 2, -1, -1);
        vs_high(3);
        exp_fd = 2;
        drive_frame(2, 4, 1'b0, 2, -1, -1);
        continuous = 1'b1; decim = 1'b1; dec_exp = 1'b1;
        vs_high(3);
        end_checks("t2", 0);

        // 2x2 decimation over a 4x4 frame with index-derived pixels.
        drive_frame(4, 4, 1'b1, 1, -1, -1);
        decim = 1'b0;
        vs_high(3);
        dec_exp = 1'b0;
        exp_fd = 3;
        end_checks("t3", 0);

        // Over-long lines set line_err; a clean frame afterwards clears it.
        drive_frame(2, 5, 1'b1, 2, -1, -1);
        vs_high(3);
        exp_fd = 4;
        end_checks("t4_long", 1);
        drive_frame(2, 4, 1'b1, 2, -1, -1);
        vs_high(3);
        exp_fd = 5;
        end_checks("t4_clean", 0);

        // Reset at pixel 3 of line 0; nothing more until the following frame.
        drive_frame(2, 4, 1'b1, 2, -1, 3);
        vs_high(3);
        end_checks("t5_rst", 0);
        drive_frame(2, 4, 1'b1, 2, -1, -1);
        vs_high(3);
        exp_fd = 6;
        end_checks("t5_after", 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
